// File: rtl/car_game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : car_game_pkg
// Description : Shared constants for the car game: state encodings, speed
//               defaults, LFSR polynomial/seed and score ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package car_game_pkg;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_countdown = 3'd1;
    localparam logic [2:0] c_st_run       = 3'd2;
    localparam logic [2:0] c_st_paused    = 3'd3;
    localparam logic [2:0] c_st_crash     = 3'd4;
    localparam logic [2:0] c_st_over      = 3'd5;

    localparam logic [19:0] c_speed_init = 20'd200000;
    localparam logic [19:0] c_speed_min  = 20'd20000;
    localparam logic [19:0] c_speed_step = 20'd15000;

    localparam logic [15:0] c_lfsr_mask = 16'hB400;
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;

    localparam logic [13:0] c_score_max = 14'd9999;

    // Speed divisor after one level-up, clamped at the floor.
    function automatic logic [19:0] next_speed(input logic [19:0] cur,
                                               input logic [19:0] floor_val,
                                               input logic [19:0] step);
        return (cur > floor_val + step) ? cur - step : floor_val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer_if
// Description : Board-input / traffic-control bundle for game_sequencer.
//               The random word is named rand_word since rand is reserved.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_sequencer_if;

    logic        btn_start;
    logic        pause_sw;
    logic        tick;
    logic        collision;
    logic        car_passed;

    logic        run;
    logic        traffic_clear;
    logic [19:0] speed;
    logic [15:0] rand_word;
    logic [13:0] score;
    logic [3:0]  level;
    logic [1:0]  countdown;
    logic [2:0]  state;
    logic        game_over;

    modport master (
        output btn_start, pause_sw, tick, collision, car_passed,
        input  run, traffic_clear, speed, rand_word, score, level,
               countdown, state, game_over
    );

    modport slave (
        input  btn_start, pause_sw, tick, collision, car_passed,
        output run, traffic_clear, speed, rand_word, score, level,
               countdown, state, game_over
    );

endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Galois LFSR, right-shifting form.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import car_game_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    output logic      [15:0] out
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= c_lfsr_seed;
        end else if (r_lfsr[0]) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ c_lfsr_mask;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]};
        end
    end

    assign out = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Game-flow FSM (idle/countdown/run/pause/crash/over) with
//               score, level, speed and random source for the traffic block.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
    import car_game_pkg::*;
#(
    parameter int          COUNT_TICKS  = 60,
    parameter int          CRASH_TICKS  = 90,
    parameter logic [19:0] SPEED_INIT   = c_speed_init,
    parameter logic [19:0] SPEED_MIN    = c_speed_min,
    parameter logic [19:0] SPEED_STEP   = c_speed_step,
    parameter int          LEVEL_POINTS = 10
)(
    input  wire logic       clk,
    input  wire logic       rst,
    game_sequencer_if.slave bus
);

    localparam int TICK_MAX = (COUNT_TICKS > CRASH_TICKS) ? COUNT_TICKS : CRASH_TICKS;
    localparam int TW       = $clog2(TICK_MAX + 1);
    localparam int PW       = $clog2(LEVEL_POINTS + 1);

    localparam logic [TW-1:0] c_count_last = TW'(COUNT_TICKS - 1);
    localparam logic [TW-1:0] c_crash_last = TW'(CRASH_TICKS - 1);
    localparam logic [PW-1:0] c_pts_last   = PW'(LEVEL_POINTS - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic          r_btn_prev;
    logic          w_start_edge;
    logic          w_start_game;
    logic [TW-1:0] r_tick_cnt;
    logic [1:0]    r_countdown;
    logic [13:0]   r_score;
    logic [3:0]    r_level;
    logic [19:0]   r_speed;
    logic [PW-1:0] r_pts;
    logic          r_traffic_clear;
    logic          w_score_inc;
    logic          w_run;
    logic          w_game_over;
    logic [15:0]   w_rand;

    assign w_start_edge = bus.btn_start & ~r_btn_prev;
    assign w_start_game = w_start_edge & ((r_state == c_st_idle) | (r_state == c_st_over));
    // A collision in the same cycle swallows the passing car.
    assign w_score_inc  = (r_state == c_st_run) & ~bus.collision & bus.car_passed
                        & (r_score < c_score_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle, c_st_over: begin
                if (w_start_edge) w_next_state = c_st_countdown;
            end
            c_st_countdown: begin
                if (bus.tick && (r_tick_cnt == c_count_last) && (r_countdown == 2'd1))
                    w_next_state = c_st_run;
            end
            c_st_run: begin
                if (bus.collision)     w_next_state = c_st_crash;
                else if (bus.pause_sw) w_next_state = c_st_paused;
            end
            c_st_paused: begin
                if (!bus.pause_sw) w_next_state = c_st_run;
            end
            c_st_crash: begin
                if (bus.tick && (r_tick_cnt == c_crash_last)) w_next_state = c_st_over;
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_run       = (r_state == c_st_run);
        w_game_over = (r_state == c_st_crash) | (r_state == c_st_over);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Held high in reset so a button already down cannot start a game.
            r_btn_prev      <= 1'b1;
            r_traffic_clear <= 1'b0;
            r_tick_cnt      <= '0;
            r_countdown     <= 2'd0;
            r_score         <= 14'd0;
            r_level         <= 4'd0;
            r_speed         <= SPEED_INIT;
            r_pts           <= '0;
        end else begin
            r_btn_prev      <= bus.btn_start;
            r_traffic_clear <= w_start_game;
            if (w_start_game) begin
                r_tick_cnt  <= '0;
                r_countdown <= 2'd3;
                r_score     <= 14'd0;
                r_level     <= 4'd0;
                r_speed     <= SPEED_INIT;
                r_pts       <= '0;
            end else begin
                case (r_state)
                    c_st_countdown: begin
                        if (bus.tick) begin
                            if (r_tick_cnt == c_count_last) begin
                                r_tick_cnt  <= '0;
                                r_countdown <= r_countdown - 2'd1;
                            end else begin
                                r_tick_cnt  <= r_tick_cnt + 1'b1;
                            end
                        end
                    end
                    c_st_run: begin
                        if (bus.collision) r_tick_cnt <= '0;
                        if (w_score_inc) begin
                            r_score <= r_score + 14'd1;
                            if (r_pts == c_pts_last) begin
                                r_pts   <= '0;
                                r_level <= (r_level == 4'd15) ? r_level : r_level + 4'd1;
                                r_speed <= next_speed(r_speed, SPEED_MIN, SPEED_STEP);
                            end else begin
                                r_pts   <= r_pts + 1'b1;
                            end
                        end
                    end
                    c_st_crash: begin
                        if (bus.tick) begin
                            r_tick_cnt <= (r_tick_cnt == c_crash_last) ? '0 : r_tick_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (w_rand)
    );

    assign bus.run           = w_run;
    assign bus.game_over     = w_game_over;
    assign bus.traffic_clear = r_traffic_clear;
    assign bus.speed         = r_speed;
    assign bus.rand_word     = w_rand;
    assign bus.score         = r_score;
    assign bus.level         = r_level;
    assign bus.countdown     = r_countdown;
    assign bus.state         = r_state;

endmodule
`default_nettype wire
